// File: rtl/axi_lite_pkg.sv
// ---------------------------------------------------------------------------
// axi_lite_pkg
// Shared constants and types for the AXI4-Lite register slave.
//   resp_t          : 2-bit AXI response code
//   RESP_OKAY       : normal completion
//   RESP_SLVERR     : write to a read-only word
//   IDX_STATUS      : word index of the read-only status input
//   IDX_ID          : word index of the read-only ID constant
//   NUM_REGS        : total words in the address map
//   NUM_RW_REGS     : words backed by writable storage (0..13)
// ---------------------------------------------------------------------------
package axi_lite_pkg;

   typedef logic [1:0] resp_t;

   localparam resp_t RESP_OKAY   = 2'b00;
   localparam resp_t RESP_SLVERR = 2'b10;

   localparam logic [3:0] IDX_STATUS = 4'd14;
   localparam logic [3:0] IDX_ID     = 4'd15;

   localparam int NUM_REGS    = 16;
   localparam int NUM_RW_REGS = 14;

   // Words below the status word are backed by storage and accept writes.
   function automatic logic idx_writable(input logic [3:0] idx);
      return (idx < IDX_STATUS);
   endfunction

endpackage

// File: rtl/axi_lite_regfile.sv
// ---------------------------------------------------------------------------
// axi_lite_regfile
// Storage for the writable words 0..13 with a byte-strobed write port and a
// combinational read port. Word 0 is also exported continuously.
//   clk, reset_n : clock, synchronous active-low reset (clears all words)
//   we           : write enable for this cycle
//   wr_idx       : word index to write
//   wr_data      : write data
//   wr_strb      : byte strobes, bit i enables byte i
//   rd_idx       : word index to read (returns 0 outside 0..13)
//   rd_data      : combinational read data
//   word0        : current contents of word 0
// ---------------------------------------------------------------------------
module axi_lite_regfile
   import axi_lite_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      we,
   input  logic [3:0]                wr_idx,
   input  logic [DATA_WIDTH-1:0]     wr_data,
   input  logic [DATA_WIDTH/8-1:0]   wr_strb,
   input  logic [3:0]                rd_idx,
   output logic [DATA_WIDTH-1:0]     rd_data,
   output logic [DATA_WIDTH-1:0]     word0
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] mem [NUM_RW_REGS];

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_RW_REGS; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         for (int i = 0; i < NUM_RW_REGS; i++) begin
            if (wr_idx == i[3:0]) begin
               for (int b = 0; b < STRB_WIDTH; b++) begin
                  if (wr_strb[b]) begin
                     mem[i][8*b +: 8] <= wr_data[8*b +: 8];
                  end
               end
            end
         end
      end
   end

   // Decoded by comparison so an index of 14/15 can never reach past the array.
   always_comb begin
      rd_data = '0;
      for (int i = 0; i < NUM_RW_REGS; i++) begin
         if (rd_idx == i[3:0]) begin
            rd_data = mem[i];
         end
      end
   end

   assign word0 = mem[0];

endmodule

// File: rtl/axi_lite_slave_regs.sv
// ---------------------------------------------------------------------------
// axi_lite_slave_regs
// AXI4-Lite slave exposing 16 x 32-bit words on a 6-bit byte address space.
// Words 0..13 are read/write, word 14 reads status_i, word 15 reads ID_VALUE.
// Word 0 is driven out on ctrl_o. Write and read channels run independently.
//   clk, reset_n           : clock, synchronous active-low reset
//   aw*                    : write address channel (awprot ignored)
//   w*                     : write data channel with byte strobes
//   b*                     : write response channel
//   ar*                    : read address channel (arprot ignored)
//   r*                     : read data channel
//   status_i               : value returned for word 14
//   ctrl_o                 : current value of word 0
//
// Handshake rule on every channel: a transfer happens at the rising edge where
// valid and ready are both high. The sender holds valid and its payload stable
// until that edge; this slave holds bvalid/bresp and rvalid/rdata/rresp stable
// until the initiator's ready completes the transfer. Readies here depend only
// on flops, never on the initiator's valids.
// ---------------------------------------------------------------------------
module axi_lite_slave_regs
   import axi_lite_pkg::*;
#(
   parameter int          ADDR_WIDTH = 6,
   parameter int          DATA_WIDTH = 32,
   parameter logic [31:0] ID_VALUE   = 32'hA11E_0001
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [ADDR_WIDTH-1:0]   awaddr,
   input  logic [2:0]              awprot,
   input  logic                    awvalid,
   output logic                    awready,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic [DATA_WIDTH/8-1:0] wstrb,
   input  logic                    wvalid,
   output logic                    wready,
   output logic [1:0]              bresp,
   output logic                    bvalid,
   input  logic                    bready,
   input  logic [ADDR_WIDTH-1:0]   araddr,
   input  logic [2:0]              arprot,
   input  logic                    arvalid,
   output logic                    arready,
   output logic [DATA_WIDTH-1:0]   rdata,
   output logic [1:0]              rresp,
   output logic                    rvalid,
   input  logic                    rready,
   input  logic [DATA_WIDTH-1:0]   status_i,
   output logic [DATA_WIDTH-1:0]   ctrl_o
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic                  rst_done;
   logic                  aw_hold;
   logic [3:0]            aw_idx;
   logic                  w_hold;
   logic [DATA_WIDTH-1:0] w_data;
   logic [STRB_WIDTH-1:0] w_strb;

   // ------------------------------------------------------------------
   // Handshakes and commit
   // ------------------------------------------------------------------
   logic                  aw_hs;
   logic                  w_hs;
   logic                  ar_hs;
   logic                  commit;
   logic [3:0]            wr_idx;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [STRB_WIDTH-1:0] wr_strb;
   logic                  wr_en;
   logic [3:0]            ar_idx;
   logic [DATA_WIDTH-1:0] rf_rd_data;
   logic [DATA_WIDTH-1:0] rd_mux;

   // bvalid blocks both write channels so only one write is ever in flight.
   assign awready = rst_done & ~aw_hold & ~bvalid;
   assign wready  = rst_done & ~w_hold  & ~bvalid;
   assign arready = rst_done & ~rvalid;

   assign aw_hs = awvalid & awready;
   assign w_hs  = wvalid  & wready;
   assign ar_hs = arvalid & arready;

   // Commit when address and data are each either latched or arriving now.
   assign commit  = (aw_hold | aw_hs) & (w_hold | w_hs);
   assign wr_idx  = aw_hold ? aw_idx : awaddr[5:2];
   assign wr_data = w_hold  ? w_data : wdata;
   assign wr_strb = w_hold  ? w_strb : wstrb;
   assign wr_en   = commit & idx_writable(wr_idx);

   assign ar_idx  = araddr[5:2];

   // Byte-lane bits and protection fields carry no meaning for this map.
   logic unused_inputs;
   assign unused_inputs = ^{awprot, arprot, awaddr[1:0], araddr[1:0]};

   // ------------------------------------------------------------------
   // Ready gating: readies stay low until the first edge out of reset.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rst_done <= 1'b0;
      end else begin
         rst_done <= 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Write address / data holding registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         aw_hold <= 1'b0;
         aw_idx  <= '0;
      end else if (commit) begin
         aw_hold <= 1'b0;
      end else if (aw_hs) begin
         aw_hold <= 1'b1;
         aw_idx  <= awaddr[5:2];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         w_hold <= 1'b0;
         w_data <= '0;
         w_strb <= '0;
      end else if (commit) begin
         w_hold <= 1'b0;
      end else if (w_hs) begin
         w_hold <= 1'b1;
         w_data <= wdata;
         w_strb <= wstrb;
      end
   end

   // ------------------------------------------------------------------
   // Write response. commit and bvalid are never high together because
   // both write readies are held low while bvalid is set.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         bvalid <= 1'b0;
         bresp  <= RESP_OKAY;
      end else if (commit) begin
         bvalid <= 1'b1;
         bresp  <= idx_writable(wr_idx) ? RESP_OKAY : RESP_SLVERR;
      end else if (bvalid && bready) begin
         bvalid <= 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // Register storage
   // ------------------------------------------------------------------
   axi_lite_regfile #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_regfile (
      .clk     (clk),
      .reset_n (reset_n),
      .we      (wr_en),
      .wr_idx  (wr_idx),
      .wr_data (wr_data),
      .wr_strb (wr_strb),
      .rd_idx  (ar_idx),
      .rd_data (rf_rd_data),
      .word0   (ctrl_o)
   );

   // ------------------------------------------------------------------
   // Read path. Storage is read before the edge, so a write committing at
   // the same edge is not yet visible to this read.
   // ------------------------------------------------------------------
   always_comb begin
      rd_mux = rf_rd_data;
      case (ar_idx)
         IDX_STATUS: rd_mux = status_i;
         IDX_ID:     rd_mux = ID_VALUE;
         default:    rd_mux = rf_rd_data;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rvalid <= 1'b0;
         rresp  <= RESP_OKAY;
         rdata  <= '0;
      end else if (ar_hs) begin
         rvalid <= 1'b1;
         rresp  <= RESP_OKAY;
         rdata  <= rd_mux;
      end else if (rvalid && rready) begin
         rvalid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
module tb_axi_lite_slave_regs;

   localparam logic [31:0] ID_CONST = 32'hA11E_0001;

   // ------------------------------------------------------------------
   // Clock / reset / DUT
   // ------------------------------------------------------------------
   logic        clk = 1'b0;
   logic        reset_n;
   logic [5:0]  awaddr;
   logic [2:0]  awprot;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [5:0]  araddr;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;
   logic [31:0] status_i;
   logic [31:0] ctrl_o;

   always #5 clk = ~clk;

   axi_lite_slave_regs #(
      .ADDR_WIDTH (6),
      .DATA_WIDTH (32),
      .ID_VALUE   (ID_CONST)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .awaddr   (awaddr),
      .awprot   (awprot),
      .awvalid  (awvalid),
      .awready  (awready),
      .wdata    (wdata),
      .wstrb    (wstrb),
      .wvalid   (wvalid),
      .wready   (wready),
      .bresp    (bresp),
      .bvalid   (bvalid),
      .bready   (bready),
      .araddr   (araddr),
      .arprot   (arprot),
      .arvalid  (arvalid),
      .arready  (arready),
      .rdata    (rdata),
      .rresp    (rresp),
      .rvalid   (rvalid),
      .rready   (rready),
      .status_i (status_i),
      .ctrl_o   (ctrl_o)
   );

   // ------------------------------------------------------------------
   // Scoreboard
   // ------------------------------------------------------------------
   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] exp_q[$];

   // Reference model of the address map: one word per index.
   logic [31:0] model_regs [16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic void model_clear();
      for (int i = 0; i < 16; i++) model_regs[i] = 32'h0;
   endfunction

   function automatic void model_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
      int idx;
      idx = int'(a) / 4;
      if (idx < 14) begin
         for (int b = 0; b < 4; b++) begin
            if (s[b]) model_regs[idx][8*b +: 8] = d[8*b +: 8];
         end
      end
   endfunction

   function automatic logic [1:0] model_bresp(input logic [5:0] a);
      return (int'(a) / 4 >= 14) ? 2'b10 : 2'b00;
   endfunction

   function automatic logic [31:0] model_read(input logic [5:0] a, input logic [31:0] st);
      int idx;
      idx = int'(a) / 4;
      if (idx == 14) return st;
      if (idx == 15) return ID_CONST;
      return model_regs[idx];
   endfunction

   // ------------------------------------------------------------------
   // Driver tasks. All drive/sample happens 1 time unit after posedge.
   // ------------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input int b_dly,
                           output logic [1:0] resp);
      int cyc   = 0;
      int bwait = 0;
      bit aw_done = 0;
      bit w_done  = 0;
      bit b_done  = 0;
      resp   = 2'bxx;
      awaddr = a;
      wdata  = d;
      wstrb  = s;
      while (!b_done && cyc < 60) begin
         awvalid = !aw_done && (cyc >= aw_dly);
         wvalid  = !w_done  && (cyc >= w_dly);
         if (bvalid) begin
            bready = (bwait >= b_dly);
            bwait++;
         end else begin
            bready = 1'b0;
         end
         if (awvalid && awready) aw_done = 1;
         if (wvalid && wready) w_done = 1;
         if (bvalid && bready) begin
            resp   = bresp;
            b_done = 1;
         end
         tick();
         cyc++;
      end
      awvalid = 1'b0;
      wvalid  = 1'b0;
      bready  = 1'b0;
      n_checks++;
      if (!b_done) begin
         n_fail++;
         $display("FAIL write_timeout: addr %h got no B response in %0d cycles", a, cyc);
      end
   endtask

   task automatic do_read(input logic [5:0] a, input int ar_dly, input int r_dly,
                          output logic [31:0] d, output logic [1:0] resp);
      int cyc   = 0;
      int rwait = 0;
      bit ar_done = 0;
      bit r_done  = 0;
      d      = 32'hxxxx_xxxx;
      resp   = 2'bxx;
      araddr = a;
      while (!r_done && cyc < 60) begin
         arvalid = !ar_done && (cyc >= ar_dly);
         if (rvalid) begin
            rready = (rwait >= r_dly);
            rwait++;
         end else begin
            rready = 1'b0;
         end
         if (arvalid && arready) ar_done = 1;
         if (rvalid && rready) begin
            d      = rdata;
            resp   = rresp;
            r_done = 1;
         end
         tick();
         cyc++;
      end
      arvalid = 1'b0;
      rready  = 1'b0;
      n_checks++;
      if (!r_done) begin
         n_fail++;
         $display("FAIL read_timeout: addr %h got no R response in %0d cycles", a, cyc);
      end
   endtask

   // ------------------------------------------------------------------
   // Vector table
   // ------------------------------------------------------------------
   typedef struct {
      bit          is_wr;
      logic [5:0]  addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [31:0] status;
      logic [1:0]  exp_resp;
      logic [31:0] exp_rdata;
      logic [31:0] exp_ctrl;
   } vec_t;

   vec_t vecs[$];

   // ------------------------------------------------------------------
   // Test body
   // ------------------------------------------------------------------
   initial begin
      logic [1:0]  r;
      logic [31:0] d;
      logic [1:0]  held_resp;

      reset_n  = 1'b0;
      awaddr   = '0; awprot = '0; awvalid = 1'b0;
      wdata    = '0; wstrb  = '0; wvalid  = 1'b0;
      bready   = 1'b0;
      araddr   = '0; arprot = '0; arvalid = 1'b0;
      rready   = 1'b0;
      status_i = '0;

      // ---------------- reset state ----------------
      repeat (3) tick();
      check("rst_awready", {31'b0, awready}, 32'd0);
      check("rst_arready", {31'b0, arready}, 32'd0);
      reset_n = 1'b1;
      tick();
      check("idle_awready", {31'b0, awready}, 32'd1);
      check("idle_wready",  {31'b0, wready},  32'd1);
      check("idle_arready", {31'b0, arready}, 32'd1);
      check("idle_bvalid",  {31'b0, bvalid},  32'd0);
      check("idle_rvalid",  {31'b0, rvalid},  32'd0);
      check("idle_ctrl",    ctrl_o,           32'd0);

      // ---------------- table-driven vectors ----------------
      //              wr   addr   data          strb   status        resp   rdata         ctrl
      vecs.push_back('{1, 6'h00, 32'hDEADBEEF, 4'hF, 32'h0,        2'b00, 32'h0,        32'hDEADBEEF});
      vecs.push_back('{0, 6'h00, 32'h0,        4'h0, 32'h0,        2'b00, 32'hDEADBEEF, 32'hDEADBEEF});
      vecs.push_back('{1, 6'h04, 32'hFFFFFFFF, 4'hF, 32'h0,        2'b00, 32'h0,        32'hDEADBEEF});
      vecs.push_back('{1, 6'h3C, 32'h12345678, 4'hF, 32'h0,        2'b10, 32'h0,        32'hDEADBEEF});
      vecs.push_back('{0, 6'h3C, 32'h0,        4'h0, 32'h0,        2'b00, 32'hA11E0001, 32'hDEADBEEF});
      vecs.push_back('{0, 6'h38, 32'h0,        4'h0, 32'h0000CAFE, 2'b00, 32'h0000CAFE, 32'hDEADBEEF});
      vecs.push_back('{1, 6'h38, 32'hFFFF0000, 4'hF, 32'h0,        2'b10, 32'h0,        32'hDEADBEEF});
      vecs.push_back('{0, 6'h07, 32'h0,        4'h0, 32'h0,        2'b00, 32'hFFFFFFFF, 32'hDEADBEEF});
      vecs.push_back('{1, 6'h34, 32'hAABBCCDD, 4'h0, 32'h0,        2'b00, 32'h0,        32'hDEADBEEF});
      vecs.push_back('{0, 6'h34, 32'h0,        4'h0, 32'h0,        2'b00, 32'h0,        32'hDEADBEEF});
      vecs.push_back('{1, 6'h36, 32'hAABBCCDD, 4'hA, 32'h0,        2'b00, 32'h0,        32'hDEADBEEF});
      vecs.push_back('{0, 6'h35, 32'h0,        4'h0, 32'h0,        2'b00, 32'hAA00CC00, 32'hDEADBEEF});
      vecs.push_back('{1, 6'h01, 32'h00000012, 4'h1, 32'h0,        2'b00, 32'h0,        32'hDEADBE12});
      vecs.push_back('{0, 6'h02, 32'h0,        4'h0, 32'h0,        2'b00, 32'hDEADBE12, 32'hDEADBE12});

      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].is_wr) begin
            do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, 0, 0, r);
            check($sformatf("vec%0d_bresp", i), {30'b0, r}, {30'b0, vecs[i].exp_resp});
         end else begin
            status_i = vecs[i].status;
            do_read(vecs[i].addr, 0, 0, d, r);
            check($sformatf("vec%0d_rdata", i), d, vecs[i].exp_rdata);
            check($sformatf("vec%0d_rresp", i), {30'b0, r}, {30'b0, vecs[i].exp_resp});
         end
         check($sformatf("vec%0d_ctrl", i), ctrl_o, vecs[i].exp_ctrl);
      end

      // ---------------- W three cycles before AW, partial strobes ----------------
      wdata = 32'h11223344; wstrb = 4'b0101; wvalid = 1'b1;
      check("wfirst_wready", {31'b0, wready}, 32'd1);
      tick();
      wvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("wfirst_wready_low", {31'b0, wready}, 32'd0);
         check("wfirst_awready", {31'b0, awready}, 32'd1);
         check("wfirst_no_bvalid", {31'b0, bvalid}, 32'd0);
         tick();
      end
      awaddr = 6'h04; awvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      check("wfirst_bvalid", {31'b0, bvalid}, 32'd1);
      check("wfirst_bresp", {30'b0, bresp}, 32'd0);
      check("wfirst_wready_during_b", {31'b0, wready}, 32'd0);
      bready = 1'b1;
      tick();
      bready = 1'b0;
      check("wfirst_b_done", {31'b0, bvalid}, 32'd0);
      check("wfirst_wready_back", {31'b0, wready}, 32'd1);
      do_read(6'h04, 0, 0, d, r);
      check("wfirst_reg1", d, 32'hFF22FF44);

      // ---------------- bready held low for 5 cycles ----------------
      awaddr = 6'h10; wdata = 32'hA5A50000; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      check("hold_bvalid_set", {31'b0, bvalid}, 32'd1);
      held_resp = bresp;
      check("hold_bresp_okay", {30'b0, held_resp}, 32'd0);
      awaddr = 6'h14; wdata = 32'h00005A5A; awvalid = 1'b1; wvalid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check("hold_bvalid", {31'b0, bvalid}, 32'd1);
         check("hold_bresp_stable", {30'b0, bresp}, {30'b0, held_resp});
         check("hold_awready", {31'b0, awready}, 32'd0);
         check("hold_wready", {31'b0, wready}, 32'd0);
         tick();
      end
      bready = 1'b1;
      tick();
      bready = 1'b0;
      check("hold_b_cleared", {31'b0, bvalid}, 32'd0);
      check("hold_awready_back", {31'b0, awready}, 32'd1);
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      check("hold_second_bvalid", {31'b0, bvalid}, 32'd1);
      bready = 1'b1;
      tick();
      bready = 1'b0;
      do_read(6'h10, 0, 0, d, r);
      check("hold_reg4", d, 32'hA5A50000);
      do_read(6'h14, 0, 0, d, r);
      check("hold_reg5", d, 32'h00005A5A);

      // ---------------- same-edge read and write to one word ----------------
      awaddr = 6'h08; wdata = 32'h00000055; wstrb = 4'hF; araddr = 6'h08;
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
      check("same_arready", {31'b0, arready}, 32'd1);
      check("same_awready", {31'b0, awready}, 32'd1);
      tick();
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      check("same_rvalid", {31'b0, rvalid}, 32'd1);
      check("same_old_value", rdata, 32'h0);
      check("same_bvalid", {31'b0, bvalid}, 32'd1);
      rready = 1'b1; bready = 1'b1;
      tick();
      rready = 1'b0; bready = 1'b0;
      do_read(6'h08, 0, 0, d, r);
      check("same_new_value", d, 32'h00000055);

      // ---------------- reset while rvalid is high ----------------
      araddr = 6'h00; arvalid = 1'b1; rready = 1'b0;
      tick();
      arvalid = 1'b0;
      check("mid_rvalid", {31'b0, rvalid}, 32'd1);
      reset_n = 1'b0;
      tick();
      check("mid_rvalid_dropped", {31'b0, rvalid}, 32'd0);
      check("mid_ctrl_cleared", ctrl_o, 32'd0);
      check("mid_arready_low", {31'b0, arready}, 32'd0);
      reset_n = 1'b1;
      tick();
      model_clear();
      check("mid_arready_back", {31'b0, arready}, 32'd1);
      check("mid_rvalid_quiet", {31'b0, rvalid}, 32'd0);
      do_read(6'h04, 0, 0, d, r);
      check("mid_reg1_cleared", d, model_read(6'h04, 32'h0));

      // ---------------- randomized traffic vs reference model ----------------
      for (int i = 0; i < 80; i++) begin
         logic [5:0]  a;
         logic [31:0] wd;
         logic [3:0]  ws;
         a = 6'($urandom_range(0, 63));
         if ($urandom_range(0, 1) == 1) begin
            wd = $urandom;
            ws = 4'($urandom_range(0, 15));
            do_write(a, wd, ws, $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 3), r);
            model_write(a, wd, ws);
            check($sformatf("rand%0d_bresp", i), {30'b0, r}, {30'b0, model_bresp(a)});
            check($sformatf("rand%0d_ctrl", i), ctrl_o, model_regs[0]);
         end else begin
            status_i = $urandom;
            exp_q.push_back(model_read(a, status_i));
            do_read(a, $urandom_range(0, 3), $urandom_range(0, 3), d, r);
            check($sformatf("rand%0d_rdata", i), d, exp_q.pop_front());
            check($sformatf("rand%0d_rresp", i), {30'b0, r}, 32'd0);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/axi_lite_slave_regs.md
Name: axi_lite_slave_regs

Overview:
AXI4-Lite responder (slave) terminating the initiator's transactions: a 16-word × 32-bit register file on a 6-bit byte address space.
- Words 0..13 are read/write.
- Word 14 is a read-only status input.
- Word 15 is a read-only ID constant.
- Word 0 drives the ctrl_o output.
- Write and read channels run independently and concurrently.

Parameters:
- ADDR_WIDTH, 6, byte address width; word index = addr[5:2].
- DATA_WIDTH, 32, data width; must be 32.
- ID_VALUE, 32'hA11E_0001, value returned for word 15.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous active-low reset.
- awaddr  in  6  write address.
- awprot  in  3  ignored.
- awvalid  in  1  write address valid.
- awready  out  1  write address ready.
- wdata  in  32  write data.
- wstrb  in  4  byte strobes.
- wvalid  in  1  write data valid.
- wready  out  1  write data ready.
- bresp  out  2  write response.
- bvalid  out  1  write response valid.
- bready  in  1  write response ready.
- araddr  in  6  read address.
- arprot  in  3  ignored.
- arvalid  in  1  read address valid.
- arready  out  1  read address ready.
- rdata  out  32  read data.
- rresp  out  2  read response.
- rvalid  out  1  read data valid.
- rready  in  1  read data ready.
- status_i  in  32  sampled as word 14.
- ctrl_o  out  32  current value of word 0.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - Regs 0..13 = 0.
  - aw_hold, w_hold, bvalid, rvalid, rst_done = 0.
  - bresp = rresp = 2'b00; rdata = 0; ctrl_o = 0.
  - All readies are 0 while in reset and become 1 on the first cycle after release (gated by the rst_done flop).
- Readies:
  - awready = rst_done & ~aw_hold & ~bvalid.
  - wready = rst_done & ~w_hold & ~bvalid.
  - arready = rst_done & ~rvalid.
  - All are combinational from flops.
- Write path:
  - An AW handshake latches awaddr[5:2] and sets aw_hold.
  - A W handshake latches wdata/wstrb and sets w_hold.
  - Either channel may arrive first or in the same cycle.
  - Commit edge: the edge at which address and data are both available (latched or handshaking in that cycle).
  - At the commit edge:
    - Index 0..13: each byte i with wstrb[i]=1 is updated; bresp=OKAY.
    - Index 14 or 15: no register changes; bresp=SLVERR (2'b10).
    - aw_hold and w_hold clear; bvalid=1 from the next cycle.
  - Latency: AW and W together at cycle T means the reg is updated at the edge ending T and bvalid is high in T+1.
  - bvalid and bresp are held stable until bready; bvalid clears at the edge where bvalid&bready.
  - No new AW/W is accepted while bvalid=1, so there is at most one outstanding write.
  - wstrb=4'b0000 to a writable index gives no change and OKAY.
- Read path:
  - An AR handshake at cycle T registers rdata and sets rresp=OKAY; rvalid=1 from T+1.
  - rdata = reg[idx] for idx 0..13, status_i sampled at the handshake edge for 14, ID_VALUE for 15.
  - rdata, rresp and rvalid are held stable until rready; rvalid clears at the edge where rvalid&rready.
  - Back-to-back reads give one read per 2 cycles minimum.
- Address handling:
  - addr[1:0] is ignored, so unaligned addresses alias to the word.
  - prot is ignored.
- Simultaneous events:
  - A read and a write commit to the same index at the same edge: the read returns the old value.
  - The new value is visible to reads whose AR handshake is at a later edge.
- Reset mid-transaction: all holds and valids are dropped immediately; the pending transaction is lost and no response is issued.
- ctrl_o equals reg[0] with no extra latency beyond the commit edge.

Decomposition:
- Package axi_lite_pkg:
  - Constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
  - IDX_STATUS=4'd14, IDX_ID=4'd15, NUM_REGS=16.
  - typedef resp_t (logic [1:0]).
- One sub-module, axi_lite_regfile: storage for words 0..13 with the byte-strobe write port and one combinational read port.
- Handshake and response control stay in the top module.

Test Plan:
- Reset then idle → cycle 0 after release: awready=wready=arready=1; bvalid=rvalid=0; ctrl_o=0.
- AW 0x00 and W 0xDEADBEEF with wstrb=4'hF in the same cycle, bready=1 → bvalid next cycle with bresp=00; ctrl_o=0xDEADBEEF; a read of 0x00 returns 0xDEADBEEF with rresp=00.
- W 0x11223344 with wstrb=4'b0101 three cycles before AW 0x04 (reg1 previously 0xFFFFFFFF) → wready low after W is accepted until B completes; reg1=0xFF22FF44.
- Write 0x3C (ID) with data 0x12345678 → bresp=2'b10; a read of 0x3C returns 0xA11E0001; a read of 0x38 with status_i=0x0000CAFE returns 0x0000CAFE.
- Hold bready=0 for 5 cycles after a write → bvalid and bresp stable; awready=wready=0 throughout; a second AW is accepted only after the B handshake.
- Same-cycle AR 0x08 and AW/W 0x08 (old 0x0, new 0x55) → rdata=0x0; the next read of 0x08 gives 0x55.
- Assert reset_n=0 while rvalid=1 → rvalid=0 after the next edge and regs cleared.
